pipe_stage_chain: RTL

- Parametrised successor to the fixed inter-stage buffers (fetch/decode, decode/EXM, EXM/write-back).
- A STAGES-deep chain of pipeline registers carrying a result payload plus write-back control.
- Adds per-stage stall and flush, valid bits, bubble insertion, occupancy count, and two register-forwarding lookup ports.
- Sits between issue and the register file; the last stage drives the write-back port.

---
 rtl/pipe_stage_chain.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_chain
// Brief    : STAGES-deep chain of pipeline registers carrying a result
//            payload plus write-back control. Provides per-stage stall and
//            flush, bubble insertion, an occupancy count and two
//            register-forwarding lookup ports. The last stage drives the
//            register-file write-back port.
// Options  : define PIPE_STAGE_PERF_EN to add o_stall_cycles and
//            o_bubble_cycles (16-bit saturating performance counters).
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_chain #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int STAGES = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_write_back,
    input  logic [ADDR_W-1:0] i_write_addr,
    input  logic [STAGES-1:0] i_stall,
    input  logic [STAGES-1:0] i_flush,
    input  logic [ADDR_W-1:0] i_src1_addr,
    input  logic [ADDR_W-1:0] i_src2_addr,
    output logic              o_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_write_back,
    output logic [ADDR_W-1:0] o_write_addr,
    output logic              o_fwd1_hit,
    output logic [DATA_W-1:0] o_fwd1_data,
    output logic              o_fwd2_hit,
    output logic [DATA_W-1:0] o_fwd2_data,
    output logic [3:0]        o_occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [15:0]       o_stall_cycles,
    output logic [15:0]       o_bubble_cycles
`endif
);

    localparam int C_LAST = STAGES - 1;

    // Stage registers and their next-state values
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] wb_q,    wb_d;
    logic [DATA_W-1:0] data_q [STAGES];
    logic [DATA_W-1:0] data_d [STAGES];
    logic [ADDR_W-1:0] addr_q [STAGES];
    logic [ADDR_W-1:0] addr_d [STAGES];

    // Effective hold per stage and the view of each stage's upstream source
    logic [STAGES-1:0] w_hold;
    logic [STAGES-1:0] w_up_hold;
    logic [STAGES-1:0] w_up_valid;
    logic [STAGES-1:0] w_up_wb;
    logic [DATA_W-1:0] w_up_data [STAGES];
    logic [ADDR_W-1:0] w_up_addr [STAGES];

    // Stall propagates upstream only: a stage holds if it or anything after it stalls
    always_comb begin
        w_hold         = '0;
        w_hold[C_LAST] = i_stall[C_LAST];
        for (int k = C_LAST - 1; k >= 0; k--) begin
            w_hold[k] = i_stall[k] | w_hold[k+1];
        end
    end

    // Source of each stage: chain inputs for stage 0, previous stage otherwise
    always_comb begin
        w_up_hold     = '0;
        w_up_valid    = '0;
        w_up_wb       = '0;
        w_up_valid[0] = i_valid;
        w_up_wb[0]    = i_write_back & i_valid;
        w_up_data[0]  = i_data;
        w_up_addr[0]  = i_write_addr;
        for (int k = 1; k < STAGES; k++) begin
            w_up_hold[k]  = w_hold[k-1];
            w_up_valid[k] = valid_q[k-1];
            w_up_wb[k]    = wb_q[k-1];
            w_up_data[k]  = data_q[k-1];
            w_up_addr[k]  = addr_q[k-1];
        end
    end

    // Per-stage update: flush, then hold, then bubble, then advance
    always_comb begin
        valid_d = valid_q;
        wb_d    = wb_q;
        data_d  = data_q;
        addr_d  = addr_q;
        for (int k = 0; k < STAGES; k++) begin
            if (i_flush[k]) begin
                // Payload is kept so a flushed-while-held stage stays stable
                valid_d[k] = 1'b0;
            end else if (w_hold[k]) begin
                valid_d[k] = valid_q[k];
            end else if (w_up_hold[k]) begin
                valid_d[k] = 1'b0;
                wb_d[k]    = 1'b0;
            end else begin
                valid_d[k] = w_up_valid[k];
                wb_d[k]    = w_up_wb[k];
                data_d[k]  = w_up_data[k];
                addr_d[k]  = w_up_addr[k];
            end
        end
    end

    // Stage register bank with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            valid_q <= '0;
            wb_q    <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
                addr_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            wb_q    <= wb_d;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
                addr_q[k] <= addr_d[k];
            end
        end
    end

    // Forwarding lookups: scan oldest to youngest so the youngest match wins
    always_comb begin
        o_fwd1_hit  = 1'b0;
        o_fwd1_data = '0;
        o_fwd2_hit  = 1'b0;
        o_fwd2_data = '0;
        for (int k = C_LAST; k >= 0; k--) begin
            if (valid_q[k] && wb_q[k] && (addr_q[k] == i_src1_addr)) begin
                o_fwd1_hit  = 1'b1;
                o_fwd1_data = data_q[k];
            end
            if (valid_q[k] && wb_q[k] && (addr_q[k] == i_src2_addr)) begin
                o_fwd2_hit  = 1'b1;
                o_fwd2_data = data_q[k];
            end
        end
    end

    // Occupancy is the number of valid stages
    always_comb begin
        o_occupancy = '0;
        for (int k = 0; k < STAGES; k++) begin
            o_occupancy = o_occupancy + {3'b000, valid_q[k]};
        end
    end

    assign o_ready      = ~w_hold[0];
    assign o_valid      = valid_q[C_LAST];
    assign o_data       = data_q[C_LAST];
    assign o_write_back = valid_q[C_LAST] & wb_q[C_LAST];
    assign o_write_addr = addr_q[C_LAST];

`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] bubble_cnt_q;
    logic        started_q;

    // Saturating counters; bubble counting starts once anything was accepted
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            started_q    <= 1'b0;
        end else begin
            if (w_hold[0] && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (started_q && !valid_q[C_LAST] && (bubble_cnt_q != 16'hFFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 16'd1;
            end
            if (i_valid && !w_hold[0]) begin
                started_q <= 1'b1;
            end
        end
    end

    assign o_stall_cycles  = stall_cnt_q;
    assign o_bubble_cycles = bubble_cnt_q;
`endif

endmodule
`default_nettype wire
